// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between the CPU control FSM and a
// debug/loader port. Round-robin on ties, registered bus outputs, wait-state
// counting, one-cycle ack to the owner and a CPU stall while its access pends.
module mem_bus_arbiter #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_ack_o,
    output logic              cpu_stall_o,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic              dbg_gnt_o,
    output logic              dbg_ack_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int unsigned CNT_W = (WAIT_CYCLES == 0) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               owner_q, owner_d;
    logic               last_owner_q, last_owner_d;
    logic               owner_we_q, owner_we_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]  cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]  dbg_rdata_q, dbg_rdata_d;
    logic               mem_en_q, mem_en_d;
    logic               mem_we_q, mem_we_d;
    logic               cpu_ack_q, cpu_ack_d;
    logic               dbg_ack_q, dbg_ack_d;
    logic               dbg_gnt_q, dbg_gnt_d;
    logic               pick_dbg;

    // State and bus registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_CPU;
            last_owner_q <= OWN_DBG;
            owner_we_q   <= 1'b0;
            cnt_q        <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            cpu_ack_q    <= 1'b0;
            dbg_ack_q    <= 1'b0;
            dbg_gnt_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            owner_we_q   <= owner_we_d;
            cnt_q        <= cnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            cpu_ack_q    <= cpu_ack_d;
            dbg_ack_q    <= dbg_ack_d;
            dbg_gnt_q    <= dbg_gnt_d;
        end
    end

    // Arbitration, wait-state counting and next values of all registered outputs.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        owner_we_d   = owner_we_q;
        cnt_d        = cnt_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        cpu_rdata_d  = cpu_rdata_q;
        dbg_rdata_d  = dbg_rdata_q;
        mem_en_d     = mem_en_q;
        mem_we_d     = mem_we_q;
        cpu_ack_d    = 1'b0;
        dbg_ack_d    = 1'b0;
        dbg_gnt_d    = dbg_gnt_q;
        // Debug wins when alone, or on a tie when the CPU had the last turn.
        pick_dbg     = dbg_req_i & (~cpu_req_i | (last_owner_q == OWN_CPU));

        unique case (state_q)
            ST_IDLE: begin
                if (cpu_req_i || dbg_req_i) begin
                    state_d      = ST_ACCESS;
                    owner_d      = pick_dbg ? OWN_DBG : OWN_CPU;
                    last_owner_d = pick_dbg ? OWN_DBG : OWN_CPU;
                    owner_we_d   = pick_dbg ? dbg_we_i : cpu_we_i;
                    mem_addr_d   = pick_dbg ? dbg_addr_i : cpu_addr_i;
                    mem_wdata_d  = pick_dbg ? dbg_wdata_i : cpu_wdata_i;
                    cnt_d        = CNT_W'(WAIT_CYCLES);
                    mem_en_d     = 1'b1;
                    mem_we_d     = pick_dbg ? dbg_we_i : cpu_we_i;
                    dbg_gnt_d    = pick_dbg;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d  = ST_RESP;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (owner_q == OWN_DBG) begin
                        dbg_ack_d = 1'b1;
                        if (!owner_we_q) dbg_rdata_d = mem_rdata_i;
                    end else begin
                        cpu_ack_d = 1'b1;
                        if (!owner_we_q) cpu_rdata_d = mem_rdata_i;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d   = ST_IDLE;
                dbg_gnt_d = 1'b0;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_en_d  = 1'b0;
                mem_we_d  = 1'b0;
                dbg_gnt_d = 1'b0;
            end
        endcase
    end

    assign cpu_rdata_o = cpu_rdata_q;
    assign cpu_ack_o   = cpu_ack_q;
    assign dbg_rdata_o = dbg_rdata_q;
    assign dbg_gnt_o   = dbg_gnt_q;
    assign dbg_ack_o   = dbg_ack_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;

    // CPU FSM holds its state until the ack cycle.
    assign cpu_stall_o = cpu_req_i & ~cpu_ack_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed checks of mem_bus_arbiter with WAIT_CYCLES=1
// (main instance) and WAIT_CYCLES=0 (second instance).
module tb_mem_bus_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack, cpu_stall;
    logic        dbg_req = 1'b0, dbg_we = 1'b0;
    logic [15:0] dbg_addr = '0;
    logic [7:0]  dbg_wdata = '0;
    logic [7:0]  dbg_rdata;
    logic        dbg_gnt, dbg_ack;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_en, mem_we;
    logic [7:0]  mem_rdata = '0;

    logic        z_cpu_req = 1'b0;
    logic [15:0] z_cpu_addr = '0;
    logic [7:0]  z_cpu_rdata, z_dbg_rdata, z_mem_wdata;
    logic        z_cpu_ack, z_cpu_stall, z_dbg_gnt, z_dbg_ack, z_mem_en, z_mem_we;
    logic [15:0] z_mem_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(16), .DATA_W(8), .WAIT_CYCLES(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
        .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata), .cpu_ack_o(cpu_ack),
        .cpu_stall_o(cpu_stall),
        .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr),
        .dbg_wdata_i(dbg_wdata), .dbg_rdata_o(dbg_rdata), .dbg_gnt_o(dbg_gnt),
        .dbg_ack_o(dbg_ack),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_en_o(mem_en),
        .mem_we_o(mem_we), .mem_rdata_i(mem_rdata)
    );

    mem_bus_arbiter #(.ADDR_W(16), .DATA_W(8), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .cpu_req_i(z_cpu_req), .cpu_we_i(1'b0), .cpu_addr_i(z_cpu_addr),
        .cpu_wdata_i(8'h00), .cpu_rdata_o(z_cpu_rdata), .cpu_ack_o(z_cpu_ack),
        .cpu_stall_o(z_cpu_stall),
        .dbg_req_i(1'b0), .dbg_we_i(1'b0), .dbg_addr_i(16'h0000),
        .dbg_wdata_i(8'h00), .dbg_rdata_o(z_dbg_rdata), .dbg_gnt_o(z_dbg_gnt),
        .dbg_ack_o(z_dbg_ack),
        .mem_addr_o(z_mem_addr), .mem_wdata_o(z_mem_wdata), .mem_en_o(z_mem_en),
        .mem_we_o(z_mem_we), .mem_rdata_i(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mem_en", 32'(mem_en), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_cpu_ack", 32'(cpu_ack), 32'h0);
        chk("rst_dbg_ack", 32'(dbg_ack), 32'h0);
        chk("rst_dbg_gnt", 32'(dbg_gnt), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 32'h0);
        chk("rst_dbg_rdata", 32'(dbg_rdata), 32'h0);
        chk("rst_z_mem_en", 32'(z_mem_en), 32'h0);

        // Test 1: CPU read 0x1234, data 0xA5 (cycle 0 is this window)
        rst_n = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234; mem_rdata = 8'hA5;
        #1;
        chk("t1_c0_stall", 32'(cpu_stall), 32'h1);
        chk("t1_c0_mem_en", 32'(mem_en), 32'h0);
        step();
        chk("t1_c1_mem_en", 32'(mem_en), 32'h1);
        chk("t1_c1_mem_we", 32'(mem_we), 32'h0);
        chk("t1_c1_mem_addr", 32'(mem_addr), 32'h1234);
        chk("t1_c1_stall", 32'(cpu_stall), 32'h1);
        chk("t1_c1_ack", 32'(cpu_ack), 32'h0);
        step();
        chk("t1_c2_mem_en", 32'(mem_en), 32'h1);
        chk("t1_c2_stall", 32'(cpu_stall), 32'h1);
        chk("t1_c2_ack", 32'(cpu_ack), 32'h0);
        step();
        chk("t1_c3_ack", 32'(cpu_ack), 32'h1);
        chk("t1_c3_rdata", 32'(cpu_rdata), 32'hA5);
        chk("t1_c3_mem_en", 32'(mem_en), 32'h0);
        chk("t1_c3_stall", 32'(cpu_stall), 32'h0);
        cpu_req = 1'b0;
        step();
        chk("t1_c4_ack", 32'(cpu_ack), 32'h0);
        chk("t1_c4_mem_en", 32'(mem_en), 32'h0);

        // Test 2: both held from reset release -> CPU, DBG, CPU
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h0020;
        mem_rdata = 8'h5A;
        step();
        chk("t2_c1_addr", 32'(mem_addr), 32'h0010);
        chk("t2_c1_gnt", 32'(dbg_gnt), 32'h0);
        step();
        step();
        chk("t2_c3_cpu_ack", 32'(cpu_ack), 32'h1);
        chk("t2_c3_dbg_ack", 32'(dbg_ack), 32'h0);
        step();
        chk("t2_c4_idle_en", 32'(mem_en), 32'h0);
        step();
        chk("t2_c5_addr", 32'(mem_addr), 32'h0020);
        chk("t2_c5_gnt", 32'(dbg_gnt), 32'h1);
        chk("t2_c5_en", 32'(mem_en), 32'h1);
        step();
        step();
        chk("t2_c7_dbg_ack", 32'(dbg_ack), 32'h1);
        chk("t2_c7_gnt", 32'(dbg_gnt), 32'h1);
        chk("t2_c7_dbg_rdata", 32'(dbg_rdata), 32'h5A);
        chk("t2_c7_cpu_ack", 32'(cpu_ack), 32'h0);
        step();
        chk("t2_c8_idle_en", 32'(mem_en), 32'h0);
        chk("t2_c8_gnt", 32'(dbg_gnt), 32'h0);
        step();
        chk("t2_c9_addr", 32'(mem_addr), 32'h0010);
        chk("t2_c9_gnt", 32'(dbg_gnt), 32'h0);
        cpu_req = 1'b0; dbg_req = 1'b0;
        step();
        step();
        chk("t2_c11_cpu_ack", 32'(cpu_ack), 32'h1);
        step();
        chk("t2_c12_en", 32'(mem_en), 32'h0);

        // Test 3: DBG write 0x00FF <- 0x3C
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h00FF; dbg_wdata = 8'h3C;
        mem_rdata = 8'hEE;
        step();
        chk("t3_c1_en", 32'(mem_en), 32'h1);
        chk("t3_c1_we", 32'(mem_we), 32'h1);
        chk("t3_c1_addr", 32'(mem_addr), 32'h00FF);
        chk("t3_c1_wdata", 32'(mem_wdata), 32'h3C);
        chk("t3_c1_gnt", 32'(dbg_gnt), 32'h1);
        step();
        chk("t3_c2_we", 32'(mem_we), 32'h1);
        chk("t3_c2_gnt", 32'(dbg_gnt), 32'h1);
        step();
        chk("t3_c3_ack", 32'(dbg_ack), 32'h1);
        chk("t3_c3_we", 32'(mem_we), 32'h0);
        chk("t3_c3_gnt", 32'(dbg_gnt), 32'h1);
        chk("t3_c3_rdata", 32'(dbg_rdata), 32'h5A);
        dbg_req = 1'b0; dbg_we = 1'b0;
        step();
        chk("t3_c4_gnt", 32'(dbg_gnt), 32'h0);
        chk("t3_c4_ack", 32'(dbg_ack), 32'h0);
        chk("t3_c4_addr_hold", 32'(mem_addr), 32'h00FF);

        // Test 4: reset in second ACCESS cycle, then a clean CPU read
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h4321; mem_rdata = 8'h77;
        step();
        step();
        chk("t4_c2_en", 32'(mem_en), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_async_en", 32'(mem_en), 32'h0);
        step();
        chk("t4_no_ack", 32'(cpu_ack), 32'h0);
        chk("t4_stall", 32'(cpu_stall), 32'h1);
        rst_n = 1'b1;
        step();
        chk("t4_r1_addr", 32'(mem_addr), 32'h4321);
        chk("t4_r1_en", 32'(mem_en), 32'h1);
        step();
        step();
        chk("t4_r3_ack", 32'(cpu_ack), 32'h1);
        chk("t4_r3_rdata", 32'(cpu_rdata), 32'h77);
        cpu_req = 1'b0;
        step();

        // Test 5: WAIT_CYCLES=0 instance, CPU read
        z_cpu_req = 1'b1; z_cpu_addr = 16'h0ABC; mem_rdata = 8'hC3;
        step();
        chk("t5_c1_en", 32'(z_mem_en), 32'h1);
        chk("t5_c1_addr", 32'(z_mem_addr), 32'h0ABC);
        chk("t5_c1_ack", 32'(z_cpu_ack), 32'h0);
        step();
        chk("t5_c2_ack", 32'(z_cpu_ack), 32'h1);
        chk("t5_c2_rdata", 32'(z_cpu_rdata), 32'hC3);
        chk("t5_c2_en", 32'(z_mem_en), 32'h0);
        z_cpu_req = 1'b0;
        step();
        chk("t5_c3_ack", 32'(z_cpu_ack), 32'h0);

        // Test 6: dbg_req dropped mid-ACCESS
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h0042; mem_rdata = 8'h99;
        step();
        dbg_req = 1'b0;
        chk("t6_c1_en", 32'(mem_en), 32'h1);
        step();
        chk("t6_c2_en", 32'(mem_en), 32'h1);
        step();
        chk("t6_c3_ack", 32'(dbg_ack), 32'h1);
        chk("t6_c3_rdata", 32'(dbg_rdata), 32'h99);
        step();
        chk("t6_c4_ack", 32'(dbg_ack), 32'h0);
        chk("t6_c4_en", 32'(mem_en), 32'h0);
        step();
        chk("t6_c5_en", 32'(mem_en), 32'h0);
        chk("t6_c5_gnt", 32'(dbg_gnt), 32'h0);
        step();
        chk("t6_c6_en", 32'(mem_en), 32'h0);
        chk("t6_c6_ack", 32'(dbg_ack), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
